// File: rtl/mult4_rr_sched.sv
// Round-robin scheduler sharing one 4x4 compressor-tree multiplier
// among NREQ requesters with per-requester response slots.
`timescale 1ns/1ps

module mult4_ct (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);
  logic [7:0] pp [4];
  logic [7:0] s1, c1, s2, c2;

  // Two 3:2 carry-save levels, then one carry-propagate add
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pp[i] = {4'b0, a_i & {4{b_i[i]}}} << i;
    end
    s1  = pp[0] ^ pp[1] ^ pp[2];
    c1  = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
    s2  = s1 ^ c1 ^ pp[3];
    c2  = ((s1 & c1) | (s1 & pp[3]) | (c1 & pp[3])) << 1;
    p_o = s2 + c2;
  end
endmodule

module mult4_rr_sched #(
  parameter int NREQ = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [4*NREQ-1:0]   req_x,
  input  logic [4*NREQ-1:0]   req_y,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [8*NREQ-1:0]   rsp_o,
  output logic                idle,
  output logic [15:0]         op_count
);
  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0]       busy_q, busy_d;
  logic [NREQ-1:0]       rv_q, rv_d;
  logic [NREQ-1:0][7:0]  prod_q, prod_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         s1_id_q, s1_id_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [3:0]            s1_x_q, s1_x_d;
  logic [3:0]            s1_y_q, s1_y_d;
  logic [15:0]           cnt_q, cnt_d;

  logic [NREQ-1:0]       rsp_hs, elig, gnt;
  logic [PW-1:0]         gnt_id;
  logic                  gnt_any;
  logic [7:0]            prod;
  logic [15:0]           hs_cnt;

  assign rsp_hs = rv_q & rsp_ready;
  assign elig   = req_valid & (~busy_q | rsp_hs);

  // Pick the eligible index with the smallest rotated distance from ptr
  always_comb begin
    logic [PW:0] off;
    logic [PW:0] best;
    off    = '0;
    best   = '1;
    gnt_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) >= ptr_q) off = (PW+1)'(i) - {1'b0, ptr_q};
      else                 off = (PW+1)'(i + NREQ) - {1'b0, ptr_q};
      if (elig[i] && off < best) begin
        best   = off;
        gnt_id = PW'(i);
      end
    end
    gnt_any = |elig;
    gnt     = '0;
    if (gnt_any) gnt = NREQ'(1) << gnt_id;
  end

  mult4_ct u_mul (
    .a_i (s1_x_q),
    .b_i (s1_y_q),
    .p_o (prod)
  );

  always_comb begin
    ptr_d      = ptr_q;
    s1_valid_d = gnt_any;
    s1_id_d    = s1_id_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    if (gnt_any) begin
      ptr_d   = (gnt_id == PW'(NREQ-1)) ? '0 : gnt_id + PW'(1);
      s1_id_d = gnt_id;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        s1_x_d = req_x[4*i +: 4];
        s1_y_d = req_y[4*i +: 4];
      end
    end
  end

  // A slot is always drained before its next product can arrive
  always_comb begin
    rv_d   = rv_q & ~rsp_ready;
    prod_d = prod_q;
    hs_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (s1_valid_q && s1_id_q == PW'(i)) begin
        rv_d[i]   = 1'b1;
        prod_d[i] = prod;
      end
      hs_cnt = hs_cnt + 16'(rsp_hs[i]);
    end
    busy_d = (busy_q & ~rsp_hs) | gnt;
    cnt_d  = cnt_q + hs_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      rv_q       <= '0;
      prod_q     <= '0;
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      cnt_q      <= '0;
    end else begin
      busy_q     <= busy_d;
      rv_q       <= rv_d;
      prod_q     <= prod_d;
      ptr_q      <= ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      cnt_q      <= cnt_d;
    end
  end

  assign req_ready = rst ? '0 : gnt;
  assign rsp_valid = rv_q;
  assign rsp_o     = prod_q;
  assign idle      = ~|busy_q & ~s1_valid_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_mult4_rr_sched.sv
// Directed bench for mult4_rr_sched with per-requester
// product scoreboard and a handshake-level reference model.
`timescale 1ns/1ps

module tb_mult4_rr_sched;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid, req_ready;
  logic [4*N-1:0]   req_x, req_y;
  logic [N-1:0]     rsp_valid, rsp_ready;
  logic [8*N-1:0]   rsp_o;
  logic             idle;
  logic [15:0]      op_count;

  always #5 clk = ~clk;

  mult4_rr_sched #(.NREQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_o     (rsp_o),
    .idle      (idle),
    .op_count  (op_count)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  sb_q [N][$];
  logic [N-1:0] m_rv  = '0;
  logic [N-1:0] m_s1  = '0;
  int           m_ptr = 0;
  logic [15:0]  m_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model sampled mid-cycle; inputs only change after posedge
  always @(negedge clk) begin
    logic [N-1:0] hs, elig, exp_rr;
    int w, idx;
    if (rst) begin
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_o", rsp_o, 0);
      chk("rst_op_count", 32'(op_count), 0);
      chk("rst_idle", 32'(idle), 1);
      for (int i = 0; i < N; i++) sb_q[i].delete();
      m_rv = '0; m_s1 = '0; m_ptr = 0; m_cnt = '0;
    end else begin
      hs     = m_rv & rsp_ready;
      elig   = req_valid & (~(m_rv | m_s1) | hs);
      exp_rr = '0;
      w      = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (w < 0 && elig[idx]) w = idx;
      end
      if (w >= 0) exp_rr[w] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rr));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      chk("op_count", 32'(op_count), 32'(m_cnt));
      chk("idle", 32'(idle), 32'((m_rv | m_s1) == '0));
      for (int i = 0; i < N; i++) begin
        if (m_rv[i]) begin
          if (sb_q[i].size() == 0) chk("sb_underflow", 1, 0);
          else chk($sformatf("rsp_o[%0d]", i), 32'(rsp_o[8*i +: 8]),
                   32'(sb_q[i][0]));
        end
      end
      for (int i = 0; i < N; i++) begin
        if (hs[i] && sb_q[i].size() > 0) void'(sb_q[i].pop_front());
        m_cnt = m_cnt + 16'(hs[i]);
        if (exp_rr[i])
          sb_q[i].push_back(8'(req_x[4*i +: 4]) * 8'(req_y[4*i +: 4]));
      end
      m_rv = (m_rv & ~rsp_ready) | m_s1;
      m_s1 = exp_rr;
      if (w >= 0) m_ptr = (w + 1) % N;
    end
  end

  task automatic look(); @(negedge clk); #1; endtask
  task automatic nxt();  @(posedge clk); #1; endtask

  task automatic do_reset();
    rst = 1'b1;
    look();
    nxt();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      look();
      ok = idle;
      nxt();
    end
    chk({tag, "_idle_timeout"}, 32'(ok), 1);
  endtask

  task automatic do_op(input int i);
    bit ok;
    ok = 1'b0;
    req_x[4*i +: 4] = 4'($urandom);
    req_y[4*i +: 4] = 4'($urandom);
    req_valid[i]    = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      look();
      ok = req_ready[i];
      nxt();
    end
    req_valid[i] = 1'b0;
    chk("op_grant_timeout", 32'(ok), 1);
    wait_idle("op");
  endtask

  task automatic rand_others(input int skip);
    for (int i = 0; i < N; i++) begin
      if (i != skip) begin
        req_valid[i]    = 1'($urandom_range(0, 1));
        rsp_ready[i]    = 1'($urandom_range(0, 1));
        req_x[4*i +: 4] = 4'($urandom);
        req_y[4*i +: 4] = 4'($urandom);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [4];
    int n, g1;
    bit ok;
    logic [N-1:0] g;
    logic [7:0] p;

    rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; rsp_ready = '1;
    look(); nxt(); look(); nxt();
    rst = 1'b0;

    // single op
    req_x[3:0] = 4'd15; req_y[3:0] = 4'd15; req_valid[0] = 1'b1;
    look();
    chk("t1_grant", 32'(req_ready), 32'h1);
    nxt();
    req_valid[0] = 1'b0;
    look(); nxt();
    look();
    chk("t1_rsp_valid", 32'(rsp_valid[0]), 1);
    chk("t1_product", 32'(rsp_o[7:0]), 32'hE1);
    nxt();
    look();
    chk("t1_count", 32'(op_count), 1);
    chk("t1_idle", 32'(idle), 1);
    nxt();

    // round-robin order
    do_reset();
    req_x = {4'd0, 4'd15, 4'd7, 4'd3};
    req_y = {4'd12, 4'd1, 4'd9, 4'd5};
    req_valid = '1;
    n = 0;
    for (int k = 0; k < 12 && req_valid != '0; k++) begin
      look();
      g = req_ready;
      for (int i = 0; i < N; i++) if (g[i] && n < 4) order[n++] = i;
      nxt();
      req_valid = req_valid & ~g;
    end
    chk("t2_ngrants", 32'(n), 4);
    for (int k = 0; k < 4; k++) chk("t2_order", 32'(order[k]), 32'(k));
    wait_idle("t2");
    look();
    chk("t2_count", 32'(op_count), 4);
    chk("t2_products", rsp_o, {8'd0, 8'd15, 8'd63, 8'd15});
    nxt();

    // backpressure on requester 1
    rsp_ready = 4'b1101;
    req_x[7:4] = 4'd7; req_y[7:4] = 4'd7;
    req_valid = 4'b0111;
    g1 = 0;
    for (int k = 0; k < 30; k++) begin
      look();
      g1 += int'(req_ready[1]);
      nxt();
      req_x[3:0] = 4'($urandom);  req_y[3:0] = 4'($urandom);
      req_x[11:8] = 4'($urandom); req_y[11:8] = 4'($urandom);
    end
    look();
    chk("t3_grants1", 32'(g1), 1);
    chk("t3_rsp_valid1", 32'(rsp_valid[1]), 1);
    chk("t3_rsp_o1", 32'(rsp_o[15:8]), 32'd49);
    nxt();
    rsp_ready[1] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < N + 3 && !ok; k++) begin
      look();
      ok = req_ready[1];
      nxt();
    end
    chk("t3_regrant", 32'(ok), 1);
    req_valid = '0;
    wait_idle("t3");

    // exhaustive products through requester 2
    for (int v = 0; v < 256; v++) begin
      p = 8'(v);
      req_x[11:8] = p[7:4];
      req_y[11:8] = p[3:0];
      req_valid[2] = 1'b1;
      rsp_ready[2] = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin
        look();
        ok = req_ready[2];
        nxt();
        rand_others(2);
      end
      if (!ok) begin
        chk("t4_grant_timeout", 0, 1);
        break;
      end
    end
    req_valid = '0;
    rsp_ready = '1;
    wait_idle("t4");

    // reset one cycle after a grant to requester 3
    req_x[15:12] = 4'd9; req_y[15:12] = 4'd9; req_valid[3] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      look();
      ok = req_ready[3];
      nxt();
    end
    chk("t5_grant3", 32'(ok), 1);
    req_valid[3] = 1'b0;
    rst = 1'b1;
    look();
    chk("t5_rst_ready", 32'(req_ready), 0);
    nxt();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      look();
      chk("t5_no_rsp", 32'(rsp_valid), 0);
      nxt();
    end
    req_x[7:0] = 8'h34; req_y[7:0] = 8'h56;
    req_valid = 4'b0011;
    look();
    chk("t5_ptr0", 32'(req_ready), 32'h1);
    nxt();
    req_valid[0] = 1'b0;
    look();
    chk("t5_next", 32'(req_ready), 32'h2);
    nxt();
    req_valid = '0;
    wait_idle("t5");

    // counter wrap
    req_valid = '1;
    for (int k = 0; k < 70000 && m_cnt < 16'd65520; k++) begin
      look();
      nxt();
      req_x = 16'($urandom);
      req_y = 16'($urandom);
    end
    req_valid = '0;
    wait_idle("t6_stream");
    for (int k = 0; k < 20 && m_cnt != 16'hFFFF; k++) do_op(0);
    look();
    chk("t6_ffff", 32'(op_count), 32'hFFFF);
    nxt();
    do_op(1);
    look();
    chk("t6_wrap", 32'(op_count), 0);
    nxt();
    rsp_ready = '0;
    req_x[7:0] = 8'hDB; req_y[7:0] = 8'hEC;
    req_valid = 4'b0011;
    for (int k = 0; k < 10 && req_valid != '0; k++) begin
      look();
      g = req_ready;
      nxt();
      req_valid = req_valid & ~g;
    end
    look(); nxt(); look(); nxt();
    look();
    chk("t6_both_valid", 32'(rsp_valid), 32'h3);
    nxt();
    rsp_ready = 4'b0011;
    look(); nxt();
    look();
    chk("t6_plus2", 32'(op_count), 2);
    nxt();
    rsp_ready = '1;
    wait_idle("t6_end");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
